// File: rtl/param_processor_pkg.sv
// param_processor_pkg: opcodes, FSM states and error bit positions shared by the processor
package param_processor_pkg;
  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SHL  = 3'd5,
    OP_MOV  = 3'd6,
    OP_HALT = 3'd7
  } op_e;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_e;
  localparam int ERR_CARRY  = 0;
  localparam int ERR_BORROW = 1;
  localparam int ERR_PC     = 2;
  localparam int ERR_CFG    = 3;
endpackage

// File: rtl/param_processor_alu.sv
// proc_alu: combinational ALU with carry (ADD/SHL) and borrow (SUB) flags
module proc_alu
  import param_processor_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  op_e               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              borrow
);
  logic [DATA_W:0] sum, diff;
  assign sum    = {1'b0, a} + {1'b0, b};
  assign diff   = {1'b0, a} - {1'b0, b};
  assign carry  = op == OP_ADD ? sum[DATA_W] : op == OP_SHL ? a[DATA_W-1] : 1'b0;
  assign borrow = op == OP_SUB && diff[DATA_W];
  // result mux; HALT produces zero and is never written back
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = sum[DATA_W-1:0];
      OP_SUB:  result = diff[DATA_W-1:0];
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SHL:  result = {a[DATA_W-2:0], 1'b0};
      OP_MOV:  result = a;
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/param_processor.sv
// param_processor: host-loaded register/program processor with a 2-cycle fetch/execute FSM
module param_processor
  import param_processor_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NREG       = 4,
  parameter int PROG_DEPTH = 8,
  localparam int REG_AW    = $clog2(NREG),
  localparam int PC_W      = $clog2(PROG_DEPTH),
  localparam int INSTR_W   = 3 + 3 * REG_AW,
  localparam int CFG_AW    = REG_AW > PC_W ? REG_AW : PC_W
) (
  input  logic               clk,
  input  logic               reset_b,
  input  logic               cfg_wr,
  input  logic               cfg_prog,
  input  logic [CFG_AW-1:0]  cfg_addr,
  input  logic [DATA_W-1:0]  cfg_data,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               enable,
  input  logic [REG_AW-1:0]  out_sel,
  output logic [DATA_W-1:0]  data_out,
  output logic               cfg_ack,
  output logic               busy,
  output logic               done,
  output logic [3:0]         error
);
  state_e              state, next;
  logic                en_q, en_q2, start;
  logic [PC_W-1:0]     pc;
  logic [INSTR_W-1:0]  instr;
  logic [DATA_W-1:0]   regs [NREG];
  logic [INSTR_W-1:0]  prog [PROG_DEPTH];
  op_e                 op;
  logic [REG_AW-1:0]   dst, src1, src2;
  logic [DATA_W-1:0]   result;
  logic                carry, borrow;
  assign op    = op_e'(instr[INSTR_W-1 -: 3]);
  assign dst   = instr[3*REG_AW-1 -: REG_AW];
  assign src1  = instr[2*REG_AW-1 -: REG_AW];
  assign src2  = instr[REG_AW-1:0];
  assign start = en_q & ~en_q2;
  assign busy  = state == S_FETCH || state == S_EXEC;
  assign done  = state == S_DONE;
  proc_alu #(.DATA_W(DATA_W)) u_alu (
    .op    (op),
    .a     (regs[src1]),
    .b     (regs[src2]),
    .result(result),
    .carry (carry),
    .borrow(borrow)
  );
  // state register
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) state <= S_IDLE;
    else state <= next;
  // next state: a low enable aborts a run; the last program word without HALT is an error
  always_comb begin
    next = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: next = start ? S_FETCH : state;
      S_FETCH: next = !enable ? S_IDLE : S_EXEC;
      S_EXEC:  next = !enable ? S_IDLE : op == OP_HALT ? S_DONE :
                      pc == PC_W'(PROG_DEPTH - 1) ? S_ERROR : S_FETCH;
      default: next = S_IDLE;
    endcase
  end
  // datapath: enable edge detect, config writes, fetch latch, execute writeback, flags, output
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      en_q     <= 1'b0;
      en_q2    <= 1'b0;
      cfg_ack  <= 1'b0;
      data_out <= '0;
      pc       <= '0;
      instr    <= '0;
      error    <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      for (int i = 0; i < PROG_DEPTH; i++) prog[i] <= '0;
    end else begin
      en_q     <= enable;
      en_q2    <= en_q;
      cfg_ack  <= cfg_wr & ~busy;
      data_out <= regs[out_sel];
      if (start && !busy) begin
        pc    <= '0;
        error <= '0;
      end
      if (cfg_wr && busy) error[ERR_CFG] <= 1'b1;
      if (cfg_wr && !busy && cfg_prog) prog[cfg_addr[PC_W-1:0]] <= prog_data;
      if (cfg_wr && !busy && !cfg_prog) regs[cfg_addr[REG_AW-1:0]] <= cfg_data;
      if (state == S_FETCH) instr <= prog[pc];
      if (state == S_EXEC && op != OP_HALT) begin
        regs[dst] <= result;
        if (carry) error[ERR_CARRY] <= 1'b1;
        if (borrow) error[ERR_BORROW] <= 1'b1;
        if (next == S_FETCH) pc <= pc + PC_W'(1);
        if (next == S_ERROR) error[ERR_PC] <= 1'b1;
      end
    end
endmodule
